cla_seq_ctrl: RTL

//   Multi-cycle wide adder sequencer. Adds WIDTH-bit operands with one SLICE-bit

---
 rtl/cla_seq_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cla_seq_ctrl.sv
// ----------------------------------------------------------------------------
// cla_seq_ctrl
//
// Multi-cycle wide adder sequencer. A WIDTH-bit addition is performed with a
// single SLICE-bit carry-lookahead slice, one slice per clock, least
// significant slice first. The carry between slices is registered, so the
// critical path is one SLICE-bit lookahead adder regardless of WIDTH.
//
// Parameters
//   WIDTH      operand/result width, an integer multiple of SLICE (>= SLICE)
//   SLICE      slice adder width; NSLICE = WIDTH/SLICE cycles per operation
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request from the producer
//   in_ready   high only while IDLE (operands accepted on valid&&ready)
//   in_a/in_b  operands
//   in_cin     carry in
//   in_sub     (only with CLA_SEQ_SUB_EN) 1 = compute a-b, in_cin ignored
//   out_valid  high only while DONE
//   out_ready  consumer accepts the result
//   out_sum    registered result, (a+b+cin) mod 2^WIDTH
//   out_cout   registered carry out of the MSB slice
//   busy       high in RUN or DONE
//
// Build option
//   CLA_SEQ_SUB_EN  when defined, adds in_sub and the subtract mode.
//
// Timing: out_valid rises NSLICE cycles after the accepting edge; minimum
// issue interval is NSLICE+2 cycles. Operations never overlap.
// ----------------------------------------------------------------------------
module cla_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic               sub_req;
    logic               accept;
    logic               last_slice;
    logic [SLICE-1:0]   sl_a;
    logic [SLICE-1:0]   sl_b;
    logic [SLICE:0]     sl_res;

    // SLICE-bit carry-lookahead adder: every carry is formed directly from the
    // generate/propagate terms and cin, without rippling through c[i].
    // Returns {cout, sum}.
    function automatic logic [SLICE:0] cla_add(input logic [SLICE-1:0] a,
                                               input logic [SLICE-1:0] b,
                                               input logic             cin);
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   c;
        logic             term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            c[i+1] = g[i];
            term   = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (term & g[j]);
                term   = term & p[j];
            end
            c[i+1] = c[i+1] | (term & cin);
        end
        return {c[SLICE], p ^ c[SLICE-1:0]};
    endfunction

`ifdef CLA_SEQ_SUB_EN
    assign sub_req = in_sub;
`else
    assign sub_req = 1'b0;
`endif

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign accept     = in_valid && in_ready;
    assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

    assign sl_a   = a_q[idx_q*SLICE +: SLICE];
    assign sl_b   = b_q[idx_q*SLICE +: SLICE];
    assign sl_res = cla_add(sl_a, sl_b, carry_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (last_slice) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture: a subtract stores ~b so the slice datapath only adds.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= in_a;
            b_q <= sub_req ? ~in_b : in_b;
        end
    end

    // Slice sequencing. Result slices are overwritten in place, so upper
    // slices keep the previous result until RUN reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        carry_q <= sub_req ? 1'b1 : in_cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    out_sum[idx_q*SLICE +: SLICE] <= sl_res[SLICE-1:0];
                    carry_q                       <= sl_res[SLICE];
                    if (last_slice) begin
                        out_cout <= sl_res[SLICE];
                        idx_q    <= '0;
                    end else begin
                        idx_q    <= idx_q + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
